// File: rtl/team_04_pkg.sv
// team_04_pkg
// Shared definitions for the team 04 keypad scanner.
//   NUM_ROWS, NUM_COLS : keypad matrix geometry (4x4)
//   KEY_CODE_W         : width of the key code handed to the core
//   scan_state_t       : scanner FSM states
//   lowest_row()       : index of the lowest asserted row bit

package team_04_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } scan_state_t;

    // Priority encoder favouring row 0, used when several keys share a column.
    function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/team_04_sync2.sv
// team_04_sync2
// Two-flop synchronizer for signals arriving asynchronously to clk.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input bus
//   q   : synchronized output bus, two cycles behind d

module team_04_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/team_04_keypad_scanner.sv
// team_04_keypad_scanner
// Column-strobing 4x4 keypad scanner with press/release debounce and a
// valid/ack handoff of one key code per press.
//   clk       : user clock
//   rst       : asynchronous active-high reset
//   en        : block enable; low forces the scanner back to idle
//   row_in    : raw active-high keypad rows, asynchronous
//   col_out   : one-hot column strobe while scanning, 0 when idle
//   key_valid : a key code is pending for the core
//   key_code  : pending code, row*4 + col
//   key_ack   : core accepts the pending code
//   overrun   : sticky, a press was dropped while a code was still pending
//   busy      : high while debouncing or holding a press

module team_04_keypad_scanner
    import team_04_pkg::*;
#(
    parameter int SCAN_DIV = 400,
    parameter int DEBOUNCE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_ROWS-1:0]   row_in,
    output logic [NUM_COLS-1:0]   col_out,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    input  logic                  key_ack,
    output logic                  overrun,
    output logic                  busy
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE);

    scan_state_t         state, state_next;
    logic [1:0]          col, col_next;
    logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
    logic [NUM_ROWS-1:0] row_cap, row_cap_next;
    logic [DWELL_W-1:0]  dwell;
    logic [NUM_ROWS-1:0] row_s;
    logic                sample;
    logic                emit;

    team_04_sync2 #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    // Decisions are taken only on the last cycle of a dwell so the rows have
    // SCAN_DIV-1 cycles to settle after a column change.
    assign sample  = (state != ST_IDLE) && (dwell == DWELL_LAST);
    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CNT_W'(1);

    // Dwell counter: held at zero while idle so the first column gets a full dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell <= '0;
        end else if (!en || state == ST_IDLE || sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DWELL_W'(1);
        end
    end

    // State register together with the column index, debounce count and captured rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            col     <= '0;
            cnt     <= '0;
            row_cap <= '0;
        end else begin
            state   <= state_next;
            col     <= col_next;
            cnt     <= cnt_next;
            row_cap <= row_cap_next;
        end
    end

    // Next-state logic. A release always restarts the scan at column 0 so the
    // lowest column wins when several keys are held.
    always_comb begin
        state_next   = state;
        col_next     = col;
        cnt_next     = cnt;
        row_cap_next = row_cap;
        emit         = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
            col_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    col_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_SCAN;
                end
                ST_SCAN: begin
                    if (sample) begin
                        if (row_s == '0) begin
                            col_next = col + 2'd1;
                        end else begin
                            row_cap_next = row_s;
                            cnt_next     = CNT_W'(1);
                            state_next   = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample) begin
                        if (row_s == row_cap) begin
                            if (cnt_inc == CNT_DONE) begin
                                emit       = 1'b1;
                                cnt_next   = '0;
                                state_next = ST_PRESSED;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end else begin
                            col_next   = col + 2'd1;
                            cnt_next   = '0;
                            state_next = ST_SCAN;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (sample) begin
                        if (row_s == '0) begin
                            if (cnt_inc == CNT_DONE) begin
                                col_next   = '0;
                                cnt_next   = '0;
                                state_next = ST_SCAN;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end else begin
                            cnt_next = '0;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output handshake. An ack in the same cycle as a new emit frees the slot,
    // so the new code is loaded instead of being counted as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else if (!en) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || key_ack) begin
                key_code  <= {lowest_row(row_cap), col};
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
        end
    end

    // Strobe and busy decode straight from the registered state.
    always_comb begin
        col_out = '0;
        if (state != ST_IDLE) begin
            col_out[col] = 1'b1;
        end
        busy = (state == ST_DEBOUNCE) || (state == ST_PRESSED);
    end

endmodule

// File: doc/team_04_keypad_scanner.md
# team_04_keypad_scanner

Sequencing controller for the 4x4 keypad on the team 04 GPIO pins. Rows arrive on GPIO[12:9] and column strobes leave on four user GPIO outputs. The block drives one column at a time, samples the synchronized rows, debounces presses and releases, and hands one key code per press to the team 04 core through a valid/ack handshake. It sits between the pad-level I/O in the team 04 wrapper and the core logic, and is gated by the wrapper's `en`.

## Interface
Parameters:
- `SCAN_DIV`, default 400: clock cycles each column is strobed (10 µs at 40 MHz); minimum 4.
- `DEBOUNCE`, default 8: consecutive matching row samples required to accept a press or a release; minimum 2.

Ports:
- `clk`  in  1  user clock, 40 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  block enable from the team 04 wrapper; low forces IDLE.
- `row_in`  in  4  raw keypad rows, active-high, asynchronous to `clk`.
- `col_out`  out  4  column strobe; one-hot active-high while scanning, 0 in IDLE.
- `key_valid`  out  1  a key code is pending.
- `key_code`  out  4  pending key code, row*4 + col.
- `key_ack`  in  1  consumer accepts the pending code.
- `overrun`  out  1  sticky: a press was dropped because the previous code was not yet acked.
- `busy`  out  1  high in DEBOUNCE and PRESSED.

## Operation
- `row_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `row_s`.
- Sample point: the last cycle of each `SCAN_DIV` dwell, giving SCAN_DIV-1 cycles of settle time.
- FSM states:
  - IDLE: `col_out`=0 and counters clear. Go to SCAN when `en`=1.
  - SCAN: strobe column c, starting at c=0. At the sample point, if `row_s`=0, advance c with wrap 3→0. Otherwise capture `row_s` into `row_cap`, set count=1 and go to DEBOUNCE while holding column c.
  - DEBOUNCE: at each sample point, if `row_s`==`row_cap`, increment count. When count reaches `DEBOUNCE`, emit the key and go to PRESSED with count=0. On a mismatch, advance c and return to SCAN.
  - PRESSED: keep strobing column c. At each sample point, if `row_s`=0, increment count, otherwise clear count. When count reaches `DEBOUNCE`, go to SCAN at c=0.
- Emit: the row is the lowest set bit of `row_cap`, and `key_code` = {row[1:0], c[1:0]}. When several keys are down, the lowest column is scanned first and the lowest row wins within it.
- Handshake:
  - `key_valid` rises with `key_code` and holds until `key_ack`=1 is sampled while valid. It then clears on the next cycle.
  - If an emit happens while valid=1 and no ack arrives in the same cycle: `key_code` is unchanged, the press is dropped and `overrun` is set.
  - If emit and ack happen in the same cycle: the new code is loaded, valid stays 1 and `overrun` is not set.
  - `key_ack` while valid=0 is ignored.
- `en` falling mid-operation: on the next edge, go to IDLE. This clears `col_out`, `key_valid`, `overrun`, c and all counters. `key_code` holds its value.

## Timing
- Reset values: `col_out`=0, `key_valid`=0, `key_code`=0, `overrun`=0, `busy`=0, state IDLE, c=0.
- First strobe: `col_out`=4'b0001 on the cycle after `en` is sampled high.
- Column change: `col_out` updates on the cycle after a sample point.
- Emit: `key_valid` rises one cycle after the DEBOUNCE-th matching sample.
- Press latency: from stable row to `key_valid`, at most 2 + 4·SCAN_DIV + (DEBOUNCE-1)·SCAN_DIV + 1 cycles.
- Release: a release needs `DEBOUNCE` consecutive zero samples, so it takes at least DEBOUNCE·SCAN_DIV cycles.
- Counters:
  - Dwell counter is ⌈log2 SCAN_DIV⌉ bits and wraps at SCAN_DIV-1.
  - Debounce counter is ⌈log2(DEBOUNCE+1)⌉ bits and saturates.

## Structure
- `team_04_pkg` holds:
  - the FSM state enum (IDLE, SCAN, DEBOUNCE, PRESSED);
  - the `NUM_ROWS`=4 and `NUM_COLS`=4 constants;
  - the key-code width constant.
- Sub-module `team_04_sync2`: a 2-flop synchronizer with a width parameter, reset to 0 by `rst`. It is instantiated once on `row_in`.
- Dwell counter, FSM, debounce counter and output register all live in `team_04_keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3 unless stated otherwise.
- Reset and idle: assert `rst` with `en`=0 → all outputs 0. Raise `en` → `col_out` steps 1,2,4,8,1 every 4 cycles.
- Single press: hold `row_in`=4'b0100 whenever `col_out`=4'b0010 → `key_valid`=1 with `key_code`=9 and `busy`=1. Assert `key_ack` for one cycle → valid clears on the next cycle.
- Bounce reject: toggle row bit 0 on column 0 with one matching sample followed by a mismatch → no `key_valid`, and scanning resumes at column 1.
- Release and repeat: press key 9, release for 3 samples, press key 9 again without acking the first → `overrun`=1 and `key_code` still 9. Ack with a simultaneous new emit in a separate run → valid stays 1 and `overrun` stays 0.
- Multi-key: rows 4'b0110 on column 2 → `key_code`=6 (row 1, col 2).
- Abort: drop `en` during DEBOUNCE, and separately during PRESSED → on the next cycle `col_out`=0, `key_valid`=0 and `busy`=0. Assert `rst` mid-dwell → outputs immediately return to their reset values.
